// File: rtl/writeback_regfile_if.sv
// -----------------------------------------------------------------------------
// writeback_regfile_if
//   Bundles the instruction/data bus between the upstream pipeline (fetch,
//   decode, execute and memory results) and the write-back/register-file
//   block, together with the two decode read ports that flow back.
//
//   Signals
//     icode, rA, rB      instruction code and register fields
//     cnd                execute condition outcome (cmovXX)
//     instr_valid        fetch reports a legal icode
//     imem_error         fetch address fault
//     dmem_error         memory-stage address fault
//     valE, valM         execute result / memory read data
//     valA, valB         register read data returned to decode
//
//   Modports
//     master  upstream side: drives the instruction/data fields, reads valA/valB
//     slave   register-file side: consumes the fields, drives valA/valB
// -----------------------------------------------------------------------------
interface writeback_regfile_if;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        cnd;
   logic        instr_valid;
   logic        imem_error;
   logic        dmem_error;
   logic [63:0] valE;
   logic [63:0] valM;
   logic [63:0] valA;
   logic [63:0] valB;

   modport master (
      output icode, rA, rB, cnd, instr_valid, imem_error, dmem_error, valE, valM,
      input  valA, valB
   );

   modport slave (
      input  icode, rA, rB, cnd, instr_valid, imem_error, dmem_error, valE, valM,
      output valA, valB
   );
endinterface

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   Y86-64 SEQ write-back stage with the 15 x 64-bit architectural register
//   file, processor status (sticky RUN/HALTED state machine) and a
//   retired-instruction counter.
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   synchronous, active-high reset
//     bus       slave modport of writeback_regfile_if (instruction fields,
//               valE/valM in, valA/valB out)
//     stat      out  3  1=AOK 2=HLT 3=ADR 4=INS (registered)
//     halted    out  1  processor is in the HALTED state
//     retired   out  CNT_W  committed-instruction count, wraps
//     dbg_sel   in   4  debug read index
//     dbg_data  out  64 R[dbg_sel], 0 for ID 0xF
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a read whose source matches a write
//                        being committed on the coming edge returns the write
//                        data (valM before valE). Otherwise reads always show
//                        the pre-edge register contents.
// -----------------------------------------------------------------------------
module writeback_regfile #(
   parameter int         NREGS  = 15,
   parameter logic [3:0] RSP_ID = 4'h4,
   parameter int         CNT_W  = 64
) (
   input  logic                clk,
   input  logic                rst,
   writeback_regfile_if.slave  bus,
   output logic [2:0]          stat,
   output logic                halted,
   output logic [CNT_W-1:0]    retired,
   input  logic [3:0]          dbg_sel,
   output logic [63:0]         dbg_data
);

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       stat_q, stat_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [63:0]      regs_q [NREGS];
   logic [63:0]      regs_d [NREGS];

   logic [3:0]       src_a_s, src_b_s, dst_e_s, dst_m_s;
   logic [2:0]       stat_next_s;
   logic             commit_s;
   logic [63:0]      view_s [16];

   // Register-ID decode from the instruction code.
   always_comb begin
      src_a_s = RNONE;
      src_b_s = RNONE;
      dst_e_s = RNONE;
      dst_m_s = RNONE;

      case (bus.icode)
         4'h2, 4'h4, 4'h6, 4'hA: src_a_s = bus.rA;
         4'h9, 4'hB:             src_a_s = RSP_ID;
         default:                src_a_s = RNONE;
      endcase

      case (bus.icode)
         4'h4, 4'h5, 4'h6:       src_b_s = bus.rB;
         4'h8, 4'h9, 4'hA, 4'hB: src_b_s = RSP_ID;
         default:                src_b_s = RNONE;
      endcase

      case (bus.icode)
         4'h3, 4'h6:             dst_e_s = bus.rB;
         4'h2:                   dst_e_s = bus.cnd ? bus.rB : RNONE;
         4'h8, 4'h9, 4'hA, 4'hB: dst_e_s = RSP_ID;
         default:                dst_e_s = RNONE;
      endcase

      case (bus.icode)
         4'h5, 4'hB: dst_m_s = bus.rA;
         default:    dst_m_s = RNONE;
      endcase
   end

   // Status of the current instruction; address faults outrank illegal
   // opcodes, which outrank halt.
   always_comb begin
      stat_next_s = STAT_AOK;
      if (bus.imem_error || bus.dmem_error) begin
         stat_next_s = STAT_ADR;
      end else if (!bus.instr_valid) begin
         stat_next_s = STAT_INS;
      end else if (bus.icode == 4'h0) begin
         stat_next_s = STAT_HLT;
      end else begin
         stat_next_s = STAT_AOK;
      end
   end

   // RUN/HALTED next state; HALTED is sticky until reset.
   always_comb begin
      state_d  = state_q;
      stat_d   = stat_q;
      commit_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (stat_next_s == STAT_AOK) begin
               commit_s = 1'b1;
            end else begin
               stat_d  = stat_next_s;
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
            stat_d  = stat_q;
         end
         default: begin
            state_d = ST_HALTED;
            stat_d  = stat_q;
         end
      endcase
   end

   // Next register contents and retire count. The valM test comes first so
   // popq %rsp (dstE == dstM) keeps the popped value; ID 0xF never matches.
   always_comb begin
      retired_d = retired_q;
      if (commit_s) begin
         retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         retired_d = retired_q;
      end
      for (int i = 0; i < NREGS; i++) begin
         if (commit_s && (dst_m_s == 4'(i))) begin
            regs_d[i] = bus.valM;
         end else if (commit_s && (dst_e_s == 4'(i))) begin
            regs_d[i] = bus.valE;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Read view indexed by the 4-bit register ID; slot 0xF reads as zero.
   // With forwarding the view is the post-edge contents, which already
   // reflect only committed writes.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
`ifdef REGFILE_BYPASS_EN
         view_s[i] = regs_d[i];
`else
         view_s[i] = regs_q[i];
`endif
      end
      view_s[15] = 64'd0;
      bus.valA   = view_s[src_a_s];
      bus.valB   = view_s[src_b_s];
      dbg_data   = view_s[dbg_sel];
   end

   // State, status, counter and register file flops; reset beats any write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         stat_q    <= STAT_AOK;
         retired_q <= {CNT_W{1'b0}};
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= 64'd0;
         end
      end else begin
         state_q   <= state_d;
         stat_q    <= stat_d;
         retired_q <= retired_d;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign stat    = stat_q;
   assign halted  = (state_q == ST_HALTED);
   assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
`timescale 1ns/1ps
module tb_writeback_regfile;

   localparam logic [2:0] AOK = 3'd1;
   localparam logic [2:0] HLT = 3'd2;
   localparam logic [2:0] ADR = 3'd3;
   localparam logic [2:0] INS = 3'd4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  dbg_sel;
   logic [63:0] dbg_data, dbg_data2;
   logic [2:0]  stat, stat2;
   logic        halted, halted2;
   logic [63:0] retired;
   logic [2:0]  retired2;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_regfile_if bus ();
   writeback_regfile_if bus2 ();

   // second instance with a 3-bit counter to exercise wrap-around
   assign bus2.icode       = bus.icode;
   assign bus2.rA          = bus.rA;
   assign bus2.rB          = bus.rB;
   assign bus2.cnd         = bus.cnd;
   assign bus2.instr_valid = bus.instr_valid;
   assign bus2.imem_error  = bus.imem_error;
   assign bus2.dmem_error  = bus.dmem_error;
   assign bus2.valE        = bus.valE;
   assign bus2.valM        = bus.valM;

   writeback_regfile #(.NREGS(15), .RSP_ID(4'h4), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .bus(bus), .stat(stat), .halted(halted),
      .retired(retired), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   writeback_regfile #(.NREGS(15), .RSP_ID(4'h4), .CNT_W(3)) dut_w (
      .clk(clk), .rst(rst), .bus(bus2), .stat(stat2), .halted(halted2),
      .retired(retired2), .dbg_sel(dbg_sel), .dbg_data(dbg_data2)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [63:0] m_regs [16];
   logic [2:0]  m_stat;
   bit          m_halted;
   logic [63:0] m_retired;

   function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
      case (ic)
         4'h2, 4'h4, 4'h6, 4'hA: return ra;
         4'h9, 4'hB:             return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
      case (ic)
         4'h4, 4'h5, 4'h6:       return rb;
         4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) return rb;
      if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
   endfunction

   function automatic logic [2:0] m_next_stat();
      if (bus.imem_error || bus.dmem_error) return ADR;
      if (!bus.instr_valid) return INS;
      if (bus.icode == 4'h0) return HLT;
      return AOK;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] idx);
      if (idx == 4'hF) return 64'd0;
      if (BYP && !m_halted && m_next_stat() == AOK) begin
         if (f_dst_m(bus.icode, bus.rA) == idx) return bus.valM;
         if (f_dst_e(bus.icode, bus.rB, bus.cnd) == idx) return bus.valE;
      end
      return m_regs[idx];
   endfunction

   task automatic model_update();
      logic [2:0] sn;
      logic [3:0] de, dm;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
         m_stat = AOK; m_halted = 1'b0; m_retired = 64'd0;
      end else if (!m_halted) begin
         sn = m_next_stat();
         if (sn == AOK) begin
            de = f_dst_e(bus.icode, bus.rB, bus.cnd);
            dm = f_dst_m(bus.icode, bus.rA);
            if (de != 4'hF) m_regs[de] = bus.valE;
            if (dm != 4'hF) m_regs[dm] = bus.valM;
            m_retired = m_retired + 64'd1;
         end else begin
            m_stat = sn; m_halted = 1'b1;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic iv, input logic ime, input logic dme,
                        input logic [63:0] ve, input logic [63:0] vm, input logic [3:0] ds);
      @(negedge clk);
      bus.icode = ic; bus.rA = ra; bus.rB = rb; bus.cnd = c;
      bus.instr_valid = iv; bus.imem_error = ime; bus.dmem_error = dme;
      bus.valE = ve; bus.valM = vm; dbg_sel = ds;
   endtask

   task automatic check_reads();
      #1;
      check("valA", bus.valA, m_read(f_src_a(bus.icode, bus.rA)));
      check("valB", bus.valB, m_read(f_src_b(bus.icode, bus.rB)));
      check("dbg_data", dbg_data, m_read(dbg_sel));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check("stat", {61'd0, stat}, {61'd0, m_stat});
      check("halted", {63'd0, halted}, {63'd0, m_halted});
      check("retired", retired, m_retired);
      check("retired_wrap", {61'd0, retired2}, {61'd0, m_retired[2:0]});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0]  ic, ra, rb;
      logic        c;
      logic [63:0] ve, vm;
      logic [3:0]  ds;
      logic [63:0] xa, xb, xd, xret;
   } vec_t;

   vec_t vt [8];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [3:0]  ic, ra, rb, ds;
      logic        c, iv, ime, dme;
      logic [63:0] ve, vm;

      for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
      m_stat = AOK; m_halted = 1'b0; m_retired = 64'd0;
      bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
      bus.instr_valid = 1'b1; bus.imem_error = 1'b0; bus.dmem_error = 1'b0;
      bus.valE = 64'd0; bus.valM = 64'd0; dbg_sel = 4'h0;

      // irmovq, OPq, pushq, popq %rsp, cmov not-taken, cmov taken, nops
      vt[0] = '{4'h3, 4'hF, 4'h3, 1'b0, 64'd5, 64'd0, 4'h3,
                64'd0, 64'd0, BYP ? 64'd5 : 64'd0, 64'd1};
      vt[1] = '{4'h6, 4'h3, 4'h1, 1'b0, 64'd7, 64'd0, 4'h1,
                64'd5, BYP ? 64'd7 : 64'd0, BYP ? 64'd7 : 64'd0, 64'd2};
      vt[2] = '{4'hA, 4'h1, 4'hF, 1'b0, 64'h1F8, 64'd0, 4'h4,
                64'd7, BYP ? 64'h1F8 : 64'd0, BYP ? 64'h1F8 : 64'd0, 64'd3};
      vt[3] = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h200, 64'h77, 4'h4,
                BYP ? 64'h77 : 64'h1F8, BYP ? 64'h77 : 64'h1F8, BYP ? 64'h77 : 64'h1F8, 64'd4};
      vt[4] = '{4'h2, 4'h3, 4'h2, 1'b0, 64'd9, 64'd0, 4'h2,
                64'd5, 64'd0, 64'd0, 64'd5};
      vt[5] = '{4'h2, 4'h4, 4'h2, 1'b1, 64'h77, 64'd0, 4'h2,
                64'h77, 64'd0, BYP ? 64'h77 : 64'd0, 64'd6};
      vt[6] = '{4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 4'hF,
                64'd0, 64'd0, 64'd0, 64'd7};
      vt[7] = '{4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 4'h2,
                64'd0, 64'd0, 64'h77, 64'd8};

      // reset state
      tick();
      check("reset_stat", {61'd0, stat}, {61'd0, AOK});
      check("reset_retired", retired, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         drive(vt[i].ic, vt[i].ra, vt[i].rb, vt[i].c, 1'b1, 1'b0, 1'b0,
               vt[i].ve, vt[i].vm, vt[i].ds);
         #1;
         check($sformatf("vec%0d_valA", i), bus.valA, vt[i].xa);
         check($sformatf("vec%0d_valB", i), bus.valB, vt[i].xb);
         check($sformatf("vec%0d_dbg", i), dbg_data, vt[i].xd);
         tick();
         check($sformatf("vec%0d_retired", i), retired, vt[i].xret);
      end

      // mrmovq with a data fault: no write, ADR, halted
      drive(4'h5, 4'h6, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'hAB, 4'h6);
      #1;
      check("fault_valB", bus.valB, 64'd5);
      check("fault_dbg_r6", dbg_data, 64'd0);
      tick();
      check("fault_stat", {61'd0, stat}, {61'd0, ADR});
      check("fault_halted", {63'd0, halted}, 64'd1);
      check("fault_retired", retired, 64'd8);

      // following irmovq is ignored while halted
      drive(4'h3, 4'hF, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 64'h55, 64'd0, 4'h6);
      #1;
      check("halted_dbg_r6", dbg_data, 64'd0);
      tick();
      check("halted_retired", retired, 64'd8);
      check("halted_stat", {61'd0, stat}, {61'd0, ADR});

      // reset clears everything; hold reset while scanning the file
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("rst_stat", {61'd0, stat}, {61'd0, AOK});
      check("rst_halted", {63'd0, halted}, 64'd0);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1;
         check($sformatf("rst_reg%0d", i), dbg_data, 64'd0);
      end
      rst = 1'b0;

      // reset asserted on the same edge as a write wins
      drive(4'h3, 4'hF, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 64'h99, 64'd0, 4'h5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(4'h1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 4'h5);
      #1;
      check("rst_over_write", dbg_data, 64'd0);
      tick();

      // status priority corners
      drive(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 4'h0);
      tick();
      check("prio_adr", {61'd0, stat}, {61'd0, ADR});
      do_reset();
      drive(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'h0);
      tick();
      check("prio_ins", {61'd0, stat}, {61'd0, INS});
      do_reset();
      drive(4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 4'h0);
      tick();
      check("prio_hlt", {61'd0, stat}, {61'd0, HLT});
      do_reset();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ic  = ($urandom_range(0, 99) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         c   = 1'($urandom_range(0, 1));
         iv  = ($urandom_range(0, 99) >= 3);
         ime = ($urandom_range(0, 99) < 2);
         dme = ($urandom_range(0, 99) < 2);
         ve  = {$urandom, $urandom};
         vm  = {$urandom, $urandom};
         ds  = 4'($urandom_range(0, 15));
         drive(ic, ra, rb, c, iv, ime, dme, ve, vm, ds);
         check_reads();
         tick();
         if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
